bt656_ycrcb_demux: RTL
======================

Name: bt656_ycrcb_demux

Overview:
- Upstream neighbour of ycrcb2rgb.
- Parses the ITU-R BT.656 4:2:2 word stream from the video ADC (Cb Y Cr Y …), strips SAV/EAV timing reference codes and upsamples chroma to 4:4:4.
- Emits one (y, cr, cb) triple per luma sample, with a valid strobe and field/blanking flags, ready for ycrcb2rgb.

Parameters:
- DATA_W, 10, width of input word and of each output component; TRS preamble is all-ones, then zero, then zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- din  in  DATA_W  BT.656 word
- din_en  in  1  din valid this cycle (27 MHz words on a faster clk); ignore din when low
- y  out  DATA_W  luma
- cr  out  DATA_W  red-difference chroma
- cb  out  DATA_W  blue-difference chroma
- pix_valid  out  1  one-cycle strobe, y/cr/cb valid
- field  out  1  F bit of most recent TRS
- vblank  out  1  V bit of most recent TRS
- hblank  out  1  H bit of most recent TRS (1 after EAV, 0 after SAV)
- sav  out  1  one-cycle pulse, SAV decoded
- eav  out  1  one-cycle pulse, EAV decoded

Behaviour:
- Reset values:
  - All outputs 0.
  - TRS FSM in IDLE.
  - Chroma phase in CB.
  - Active flag cleared, so no pixels until the first SAV.
- All state advances only on cycles with din_en=1; din_en=0 cycles hold all state; strobes are 0.
- TRS detector FSM: IDLE -> ONES (din all-ones) -> Z1 (din==0) -> Z2 (din==0) -> XY.
  - XY word decode: F=din[DATA_W-2], V=din[DATA_W-3], H=din[DATA_W-4]. Protection bits are ignored; no error correction.
  - In ONES or Z1, a non-matching word returns the FSM to IDLE. Exception: an all-ones word restarts at ONES. The active flag clears, and pixels stay suppressed until the next SAV.
  - Preamble and XY words are never treated as video samples.
- XY decode, registered 1 clk after the XY word:
  - field, vblank and hblank update.
  - H=0 pulses sav; H=1 pulses eav.
  - SAV with V=0 sets active and forces phase to CB.
  - Any EAV, or any SAV with V=1, clears active.
- Active video: the phase cycles CB -> Y0 -> CR -> Y1 -> CB, one step per din_en word.
  - CB: latch cb.
  - Y0: latch y0.
  - CR: output y=y0, cb=latched cb, cr=din; pix_valid=1.
  - Y1: output y=din with the same cb/cr; pix_valid=1.
- Latency: outputs are registered; pix_valid asserts the clk after the CR or Y1 word's din_en cycle.
- Output data holds its last value when pix_valid=0.
- Boundaries:
  - EAV arriving mid-quad (phase not CB) discards the partial pixel; no pix_valid.
  - All-ones seen during active video is taken as a TRS preamble; the pixel quad in progress is abandoned.
  - rst asserted mid-line returns everything to reset values on the next clk.

Decomposition:
- Package bt656_pkg: TRS_ONES and TRS_ZERO constants, the XY bit-index localparams, the TRS state enum (IDLE, ONES, Z1, Z2, XY) and the chroma phase enum (CB, Y0, CR, Y1).
- One natural sub-module: bt656_trs_detect, containing the FSM. It outputs an is_trs_word mask, an xy_valid pulse and decoded F/V/H.
- The top level holds the phase counter and the output registers.

Test Plan:
- Reset: assert rst 3 clks with din_en toggling -> all outputs 0; no pix_valid for data words sent before any SAV.
- Active line: SAV (3FF,000,000,200), then 208,120,2B4,188 -> sav pulse; pixels (y=120,cb=208,cr=2B4) then (y=188,cb=208,cr=2B4); hblank=0, vblank=0, field=0.
- Gapped enable: same stream with din_en=1 every third clk -> identical pixel sequence, each pix_valid exactly 1 clk wide, nothing on idle cycles.
- EAV mid-quad: SAV, 208,120, then EAV (3FF,000,000,240) -> no pix_valid; eav pulse; hblank=1. Following 208,120,2B4,188 produce no pixels.
- Vertical blank and field: SAV XY=280 then a data quad -> vblank=1, no pixels. SAV XY=300 then quad 220,188,2E8,100 -> field=1, vblank=0; pixels (188,220,2E8) and (100,220,2E8).
- Malformed preamble/reset mid-line: SAV, 208, then 3FF,123 -> FSM back to IDLE, no pixels until the next SAV. Assert rst mid-quad -> outputs 0 on the next clk.

Source files
------------

// File: rtl/bt656_pkg.sv
// Shared constants and state encodings for the BT.656 demultiplexer.
package bt656_pkg;

  // Fill bits of the TRS preamble words (all-ones, then two all-zeros).
  localparam logic TRS_ONES = 1'b1;
  localparam logic TRS_ZERO = 1'b0;

  // XY flag positions, as offsets below the word width.
  localparam int XY_F_OFS = 2;
  localparam int XY_V_OFS = 3;
  localparam int XY_H_OFS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONES,
    ST_Z1,
    ST_Z2,
    ST_XY
  } trs_state_e;

  typedef enum logic [1:0] {
    PH_CB,
    PH_Y0,
    PH_CR,
    PH_Y1
  } phase_e;

endpackage

// File: rtl/bt656_trs_detect.sv
// Tracks the 3FF/000/000/XY timing reference sequence and flags its words.
module bt656_trs_detect
  import bt656_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_en,
  output logic              is_trs_word,
  output logic              xy_valid,
  output logic              f,
  output logic              v,
  output logic              h,
  output trs_state_e        state_o
);

  localparam logic [DATA_W-1:0] ONES_W = {DATA_W{TRS_ONES}};
  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{TRS_ZERO}};

  trs_state_e state_q, state_d;
  logic       din_ones, din_zero;

  assign din_ones = (din == ONES_W);
  assign din_zero = (din == ZERO_W);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    is_trs_word = 1'b0;
    xy_valid    = 1'b0;
    f           = din[DATA_W-XY_F_OFS];
    v           = din[DATA_W-XY_V_OFS];
    h           = din[DATA_W-XY_H_OFS];
    case (state_q)
      ST_ONES, ST_Z1: is_trs_word = din_ones || din_zero;
      ST_Z2:          is_trs_word = 1'b1;
      default:        is_trs_word = din_ones;
    endcase
    if (din_en) begin
      case (state_q)
        ST_ONES: state_d = din_ones ? ST_ONES : (din_zero ? ST_Z1 : ST_IDLE);
        ST_Z1:   state_d = din_ones ? ST_ONES : (din_zero ? ST_Z2 : ST_IDLE);
        ST_Z2: begin
          // The word after the second zero is always the XY word.
          xy_valid = 1'b1;
          state_d  = ST_XY;
        end
        default: state_d = din_ones ? ST_ONES : ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/bt656_ycrcb_demux.sv
// BT.656 4:2:2 word stream to per-luma (y, cr, cb) triples with timing flags.
module bt656_ycrcb_demux
  import bt656_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_en,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] cb,
  output logic              pix_valid,
  output logic              field,
  output logic              vblank,
  output logic              hblank,
  output logic              sav,
  output logic              eav
);

  logic       is_trs_word, xy_valid, xy_f, xy_v, xy_h;
  logic       preamble_broken;
  trs_state_e trs_state;

  bt656_trs_detect #(.DATA_W(DATA_W)) u_trs (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_en      (din_en),
    .is_trs_word (is_trs_word),
    .xy_valid    (xy_valid),
    .f           (xy_f),
    .v           (xy_v),
    .h           (xy_h),
    .state_o     (trs_state)
  );

  phase_e            phase_q, phase_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] cb_lat_q, cb_lat_d, y0_q, y0_d;
  logic [DATA_W-1:0] y_q, y_d, cr_q, cr_d, cb_q, cb_d;
  logic              pix_valid_q, pix_valid_d, sav_q, sav_d, eav_q, eav_d;
  logic              field_q, field_d, vblank_q, vblank_d, hblank_q, hblank_d;

  // A word that breaks a started preamble (other than a fresh all-ones).
  assign preamble_broken = ((trs_state == ST_ONES) || (trs_state == ST_Z1)) && !is_trs_word;

  always_comb begin
    phase_d     = phase_q;
    active_d    = active_q;
    cb_lat_d    = cb_lat_q;
    y0_d        = y0_q;
    y_d         = y_q;
    cr_d        = cr_q;
    cb_d        = cb_q;
    field_d     = field_q;
    vblank_d    = vblank_q;
    hblank_d    = hblank_q;
    pix_valid_d = 1'b0;
    sav_d       = 1'b0;
    eav_d       = 1'b0;
    if (din_en) begin
      if (xy_valid) begin
        field_d  = xy_f;
        vblank_d = xy_v;
        hblank_d = xy_h;
        sav_d    = !xy_h;
        eav_d    = xy_h;
        active_d = !xy_h && !xy_v;
        phase_d  = PH_CB;
      end else if (is_trs_word) begin
        phase_d = PH_CB;
      end else if (preamble_broken) begin
        active_d = 1'b0;
        phase_d  = PH_CB;
      end else if (active_q) begin
        case (phase_q)
          PH_CB: begin
            cb_lat_d = din;
            phase_d  = PH_Y0;
          end
          PH_Y0: begin
            y0_d    = din;
            phase_d = PH_CR;
          end
          PH_CR: begin
            y_d         = y0_q;
            cb_d        = cb_lat_q;
            cr_d        = din;
            pix_valid_d = 1'b1;
            phase_d     = PH_Y1;
          end
          default: begin
            // Second luma reuses the chroma pair already on the outputs.
            y_d         = din;
            pix_valid_d = 1'b1;
            phase_d     = PH_CB;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_CB;
      active_q    <= 1'b0;
      cb_lat_q    <= '0;
      y0_q        <= '0;
      y_q         <= '0;
      cr_q        <= '0;
      cb_q        <= '0;
      field_q     <= 1'b0;
      vblank_q    <= 1'b0;
      hblank_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      sav_q       <= 1'b0;
      eav_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      active_q    <= active_d;
      cb_lat_q    <= cb_lat_d;
      y0_q        <= y0_d;
      y_q         <= y_d;
      cr_q        <= cr_d;
      cb_q        <= cb_d;
      field_q     <= field_d;
      vblank_q    <= vblank_d;
      hblank_q    <= hblank_d;
      pix_valid_q <= pix_valid_d;
      sav_q       <= sav_d;
      eav_q       <= eav_d;
    end
  end

  assign y         = y_q;
  assign cr        = cr_q;
  assign cb        = cb_q;
  assign pix_valid = pix_valid_q;
  assign field     = field_q;
  assign vblank    = vblank_q;
  assign hblank    = hblank_q;
  assign sav       = sav_q;
  assign eav       = eav_q;

endmodule
